// File: rtl/axi_read_arbiter.sv
// Two-client AXI4 read arbiter: round-robin AR grants through a registered stage,
// with an order FIFO that steers each returning R burst back to its owner.
module axi_read_arbiter #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [7:0]                    S0_ARLEN,
    input  logic                          S0_ARVALID,
    output logic                          S0_ARREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [7:0]                    S1_ARLEN,
    input  logic                          S1_ARVALID,
    output logic                          S1_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] S0_RDATA,
    output logic [1:0]                    S0_RRESP,
    output logic                          S0_RLAST,
    output logic                          S0_RVALID,
    input  logic                          S0_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] S1_RDATA,
    output logic [1:0]                    S1_RRESP,
    output logic                          S1_RLAST,
    output logic                          S1_RVALID,
    input  logic                          S1_RREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]                    M_ARLEN,
    output logic [2:0]                    M_ARSIZE,
    output logic [1:0]                    M_ARBURST,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]                    M_RRESP,
    input  logic                          M_RLAST,
    input  logic                          M_RVALID,
    output logic                          M_RREADY,
    output logic                          ERR
);
    localparam int CW = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int PW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;

    logic [CW-1:0] cnt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          fifo [C_MAX_OUTSTANDING];
    logic          last_grant;
    logic          head, nonempty, ar_hs, pop, stage_free, can_grant;
    logic          win0, win1, grant, gsel;
    logic [CW:0]   pending;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(C_MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign M_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_ARBURST = 2'b01;

    // The outstanding count doubles as the order FIFO occupancy.
    assign nonempty   = (cnt != '0);
    assign head       = fifo[rd_ptr];
    assign ar_hs      = M_ARVALID & M_ARREADY;
    assign pop        = M_RVALID & M_RREADY & M_RLAST;
    assign stage_free = ~M_ARVALID | M_ARREADY;
    assign pending    = {1'b0, cnt} + (CW+1)'(M_ARVALID) - (CW+1)'(pop);
    assign can_grant  = ~RST & stage_free & (pending < (CW+1)'(C_MAX_OUTSTANDING));

    assign win0       = S0_ARVALID & (~S1_ARVALID | last_grant);
    assign win1       = S1_ARVALID & (~S0_ARVALID | ~last_grant);
    assign S0_ARREADY = can_grant & win0;
    assign S1_ARREADY = can_grant & win1;
    assign grant      = S0_ARREADY | S1_ARREADY;
    assign gsel       = S1_ARREADY;

    assign S0_RDATA  = M_RDATA;
    assign S1_RDATA  = M_RDATA;
    assign S0_RRESP  = M_RRESP;
    assign S1_RRESP  = M_RRESP;
    assign S0_RLAST  = M_RLAST;
    assign S1_RLAST  = M_RLAST;
    assign S0_RVALID = M_RVALID & nonempty & ~head;
    assign S1_RVALID = M_RVALID & nonempty & head;
    assign M_RREADY  = nonempty & (head ? S1_RREADY : S0_RREADY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            M_ARVALID  <= 1'b0;
            M_ARID     <= '0;
            M_ARADDR   <= '0;
            M_ARLEN    <= '0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ERR        <= 1'b0;
        end else begin
            if (grant) begin
                M_ARVALID  <= 1'b1;
                M_ARID     <= C_M_AXI_ID_WIDTH'(gsel);
                M_ARADDR   <= gsel ? S1_ARADDR : S0_ARADDR;
                M_ARLEN    <= gsel ? S1_ARLEN : S0_ARLEN;
                last_grant <= gsel;
            end else if (ar_hs) begin
                M_ARVALID <= 1'b0;
            end
            case ({ar_hs, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            // Stray beats and ID mismatches are flagged but never rerouted.
            if (M_RVALID & (~nonempty | (M_RID != C_M_AXI_ID_WIDTH'(head))))
                ERR <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (ar_hs) fifo[wr_ptr] <= M_ARID[0];
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a cycle table for grant order and R steering,
// then hand sequences for the outstanding limit, AR stall, RREADY backpressure and reset.
module tb_axi_read_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] S0_ARADDR = 32'h1000, S1_ARADDR = 32'h2000;
    logic [7:0]  S0_ARLEN = 8'd3, S1_ARLEN = 8'd0;
    logic        S0_ARVALID = 0, S1_ARVALID = 0, S0_ARREADY, S1_ARREADY;
    logic [511:0] S0_RDATA, S1_RDATA;
    logic [1:0]  S0_RRESP, S1_RRESP;
    logic        S0_RLAST, S1_RLAST, S0_RVALID, S1_RVALID;
    logic        S0_RREADY = 1, S1_RREADY = 1;
    logic [0:0]  M_ARID;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARVALID, M_ARREADY = 0;
    logic [0:0]  M_RID = 0;
    logic [511:0] M_RDATA = {16{32'hdead_beef}};
    logic [1:0]  M_RRESP = 2'b00;
    logic        M_RLAST = 0, M_RVALID = 0, M_RREADY, ERR;

    axi_read_arbiter dut (
        .CLK(CLK), .RST(RST),
        .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // in: {s0v, s1v, m_arready, m_rvalid, m_rlast, m_rid}
    // ar: {s0_arready, s1_arready, m_arvalid, m_arid}; r: {m_rready, s0_rvalid, s1_rvalid, err}
    typedef struct {
        logic [5:0]  in;
        logic [3:0]  ar;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  r;
    } vec_t;

    vec_t tbl [13];
    int   n_vec = 0;
    int   n_bad = 0;
    int   grants, hs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        S0_ARVALID = 0; S1_ARVALID = 0; M_ARREADY = 0;
        M_RVALID = 0; M_RLAST = 0; M_RID = 0; S0_RREADY = 1; S1_RREADY = 1;
    endtask

    task automatic do_reset();
        idle();
        #2 RST = 1;
        @(negedge CLK);
        RST = 0;
    endtask

    // Sample grant/handshake activity 1ns after the inputs settle, then move to the next cycle.
    task automatic cyc();
        #1;
        if (S0_ARREADY) grants++;
        if (M_ARVALID && M_ARREADY) hs++;
        @(negedge CLK);
    endtask

    initial begin
        tbl[0]  = '{6'b000000, 4'b0000, 32'h0,    8'd0, 4'b0000};
        tbl[1]  = '{6'b111000, 4'b1000, 32'h0,    8'd0, 4'b0000};
        tbl[2]  = '{6'b111000, 4'b0110, 32'h1000, 8'd3, 4'b0000};
        tbl[3]  = '{6'b001000, 4'b0011, 32'h2000, 8'd0, 4'b1000};
        tbl[4]  = '{6'b000100, 4'b0001, 32'h2000, 8'd0, 4'b1100};
        tbl[5]  = '{6'b000100, 4'b0001, 32'h2000, 8'd0, 4'b1100};
        tbl[6]  = '{6'b000100, 4'b0001, 32'h2000, 8'd0, 4'b1100};
        tbl[7]  = '{6'b000110, 4'b0001, 32'h2000, 8'd0, 4'b1100};
        tbl[8]  = '{6'b000111, 4'b0001, 32'h2000, 8'd0, 4'b1010};
        tbl[9]  = '{6'b000000, 4'b0001, 32'h2000, 8'd0, 4'b0000};
        tbl[10] = '{6'b000100, 4'b0001, 32'h2000, 8'd0, 4'b0000};
        tbl[11] = '{6'b000000, 4'b0001, 32'h2000, 8'd0, 4'b0001};
        tbl[12] = '{6'b000000, 4'b0001, 32'h2000, 8'd0, 4'b0001};

        repeat (2) @(negedge CLK);
        RST = 0;
        chk("arsize", 64'(M_ARSIZE), 64'd6);
        chk("arburst", 64'(M_ARBURST), 64'd1);

        // Grant order, R steering by the order FIFO, stray beat sets ERR.
        for (int i = 0; i < 13; i++) begin
            {S0_ARVALID, S1_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RID} = tbl[i].in;
            #1;
            chk($sformatf("v%0d_ar", i), 64'({S0_ARREADY, S1_ARREADY, M_ARVALID, M_ARID}), 64'(tbl[i].ar));
            chk($sformatf("v%0d_addr", i), 64'(M_ARADDR), 64'(tbl[i].addr));
            chk($sformatf("v%0d_len", i), 64'(M_ARLEN), 64'(tbl[i].len));
            chk($sformatf("v%0d_r", i), 64'({M_RREADY, S0_RVALID, S1_RVALID, ERR}), 64'(tbl[i].r));
            if (i == 7) chk("s0_rlast_copy", 64'(S0_RLAST), 64'd1);
            if (i == 8) chk("s1_rdata_copy", 64'(S1_RDATA[31:0]), 64'hdead_beef);
            @(negedge CLK);
        end

        // Outstanding limit: S0 keeps asking, only 4 bursts go out until one completes.
        do_reset();
        S0_ARLEN = 8'd0; S0_ARVALID = 1; M_ARREADY = 1;
        grants = 0; hs = 0;
        repeat (12) cyc();
        chk("limit_grants", 64'(grants), 64'd4);
        chk("limit_hs", 64'(hs), 64'd4);
        chk("limit_arready_low", 64'(S0_ARREADY), 64'd0);
        M_RVALID = 1; M_RLAST = 1; M_RID = 0;
        #1;
        chk("pop_cycle_grant", 64'(S0_ARREADY), 64'd1);
        chk("pop_cycle_rready", 64'(M_RREADY), 64'd1);
        grants++;
        @(negedge CLK);
        M_RVALID = 0; M_RLAST = 0;
        repeat (8) cyc();
        chk("limit_grants_after_pop", 64'(grants), 64'd5);
        chk("limit_hs_after_pop", 64'(hs), 64'd5);

        // RID mismatch is flagged; async reset mid-burst clears everything.
        M_RVALID = 1; M_RID = 1;
        #1;
        chk("mismatch_routed_by_head", 64'({S0_RVALID, S1_RVALID}), 64'b10);
        @(negedge CLK);
        M_RVALID = 0; M_RID = 0;
        #1;
        chk("err_rid_mismatch", 64'(ERR), 64'd1);
        RST = 1;
        #1;
        chk("rst_ar", 64'({S0_ARREADY, S1_ARREADY, M_ARVALID, M_ARID}), 64'd0);
        chk("rst_addr_len", 64'({M_ARADDR, M_ARLEN}), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        M_RVALID = 1;
        #1;
        chk("rst_fifo_empty", 64'({M_RREADY, S0_RVALID, S1_RVALID}), 64'd0);
        @(negedge CLK);
        RST = 0; M_RVALID = 0;
        S0_ARVALID = 1; S1_ARVALID = 1;
        #1;
        chk("post_rst_grant", 64'({S0_ARREADY, S1_ARREADY}), 64'b10);
        @(negedge CLK);

        // AR stall holds the stage; then RREADY backpressure from the owning client.
        do_reset();
        S0_ARLEN = 8'd3;
        S0_ARVALID = 1; S1_ARVALID = 1;
        cyc();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("stall%0d_ar", c), 64'({S0_ARREADY, S1_ARREADY, M_ARVALID, M_ARID}), 64'b0010);
            chk($sformatf("stall%0d_addr", c), 64'({M_ARADDR, M_ARLEN}), 64'({32'h1000, 8'd3}));
            @(negedge CLK);
        end
        M_ARREADY = 1;
        #1;
        chk("stall_release_s1", 64'({S0_ARREADY, S1_ARREADY}), 64'b01);
        @(negedge CLK);
        S0_ARVALID = 0; S1_ARVALID = 0;
        #1;
        chk("s1_issued", 64'({M_ARVALID, M_ARID, M_ARADDR}), 64'({1'b1, 1'b1, 32'h2000}));
        @(negedge CLK);
        M_ARREADY = 0;
        M_RVALID = 1; M_RID = 0; S0_RREADY = 0;
        #1;
        chk("bp_rready", 64'(M_RREADY), 64'd0);
        chk("bp_rvalid", 64'({S0_RVALID, S1_RVALID}), 64'b10);
        chk("bp_err", 64'(ERR), 64'd0);
        @(negedge CLK);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-requester AXI4 read-channel arbiter that shares one AXI master read port (address channel AR, data channel R) of the DUT processor between two internal clients, S0 and S1.
- Grants address requests round-robin, one burst per grant, through a registered AR stage.
- Records grant order in an order FIFO and steers each returning R burst to its owner.
- Sits between the processor's internal DMA/fetch clients and the top-level M0_AR*/M0_R* ports.

Parameters:
- C_M_AXI_ID_WIDTH, 1, width of M_ARID/M_RID; must be >= 1.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 512, data width; sets fixed ARSIZE = log2(C_M_AXI_DATA_WIDTH/8).
- C_MAX_OUTSTANDING, 4, maximum bursts issued but not completed (order FIFO depth); range 1..16.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- S0_ARADDR / S1_ARADDR  in  C_M_AXI_ADDR_WIDTH  requester burst start address.
- S0_ARLEN / S1_ARLEN  in  8  requester burst length minus 1.
- S0_ARVALID / S1_ARVALID  in  1  requester address valid.
- S0_ARREADY / S1_ARREADY  out  1  requester address accepted.
- S0_RDATA / S1_RDATA  out  C_M_AXI_DATA_WIDTH  read data; both are copies of M_RDATA.
- S0_RRESP / S1_RRESP  out  2  read response; both are copies of M_RRESP.
- S0_RLAST / S1_RLAST  out  1  last beat; both are copies of M_RLAST.
- S0_RVALID / S1_RVALID  out  1  beat valid to owning requester.
- S0_RREADY / S1_RREADY  in  1  requester beat ready.
- M_ARID  out  C_M_AXI_ID_WIDTH  granted requester index, zero-extended.
- M_ARADDR  out  C_M_AXI_ADDR_WIDTH  registered address.
- M_ARLEN  out  8  registered length.
- M_ARSIZE  out  3  constant log2(C_M_AXI_DATA_WIDTH/8).
- M_ARBURST  out  2  constant 2'b01 (INCR).
- M_ARVALID  out  1  address valid.
- M_ARREADY  in  1  address accepted.
- M_RID  in  C_M_AXI_ID_WIDTH  response ID; checked, not used for routing.
- M_RDATA  in  C_M_AXI_DATA_WIDTH  read data.
- M_RRESP  in  2  read response.
- M_RLAST  in  1  last beat.
- M_RVALID  in  1  beat valid.
- M_RREADY  out  1  beat ready.
- ERR  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-high.
- Reset values: M_ARVALID=0; M_ARID/M_ARADDR/M_ARLEN=0; S*_ARREADY=0; order FIFO empty; outstanding count=0; ERR=0; last_grant=1, so S0 wins the first tie.
- RST asserted mid-burst: all state clears immediately. In-flight bursts are abandoned; the bench must also reset the slave.
- Outstanding count (cnt), width clog2(C_MAX_OUTSTANDING+1):
  - +1 on M AR handshake (M_ARVALID & M_ARREADY).
  - -1 on final R beat (M_RVALID & M_RREADY & M_RLAST).
  - Both in the same cycle: unchanged.
- AR stage is free when M_ARVALID=0, or when M_ARVALID & M_ARREADY this cycle.
- Grant condition: stage free AND (cnt + M_ARVALID − pop) < C_MAX_OUTSTANDING.
- Arbitration:
  - Only one valid requester: that one wins.
  - Both valid: the requester != last_grant wins.
- Grant cycle t:
  - S{w}_ARREADY=1 combinationally in cycle t; never asserted for both requesters.
  - ADDR, LEN and ID=w are captured; M_ARVALID=1 from t+1; last_grant<=w.
- Back-to-back: grant latency is one cycle; with M_ARREADY tied high, a grant is possible every cycle.
- While M_ARVALID=1 & M_ARREADY=0: M_ARID, M_ARADDR, M_ARLEN are held stable and no grant occurs.
- Order FIFO:
  - Pushes the ID on M AR handshake; pops on final R beat.
  - Push and pop in the same cycle are both honoured.
  - Never overflows, guaranteed by the grant condition.
- R routing (owner h = FIFO head), zero latency, combinational:
  - S{h}_RVALID = M_RVALID & nonempty; the other requester's RVALID=0.
  - M_RREADY = S{h}_RREADY & nonempty.
- M_RVALID with FIFO empty: M_RREADY=0 (stall) and ERR<=1.
- M_RVALID & nonempty & M_RID != head: the beat is still routed by head and ERR<=1.
- ERR clears only on RST.
- Non-owner RREADY is ignored.

Test Plan:
- Reset, then S0 and S1 assert ARVALID in the same cycle (S0 addr 0x1000, S1 addr 0x2000), M_ARREADY=1 -> S0_ARREADY first, M_ARID=0/ARADDR=0x1000; next grant S1, M_ARID=1/ARADDR=0x2000; M_ARSIZE=6, M_ARBURST=1.
- C_MAX_OUTSTANDING=4, M_RVALID=0, S0 issues 6 requests -> exactly 4 M AR handshakes; S0_ARREADY stays 0 until the first RLAST pop, then the 5th request is granted.
- Grant S0 with ARLEN=3, then S1 with ARLEN=0; slave returns 5 beats with correct RIDs -> beats 1-4 raise S0_RVALID only (S0_RLAST on beat 4), beat 5 raises S1_RVALID; ERR=0.
- Hold M_ARREADY=0 for 10 cycles with both requesters valid -> M_AR* outputs stable, no S*_ARREADY; then hold S0_RREADY=0 while S0 owns a burst -> M_RREADY=0 and S1_RVALID=0.
- Drive M_RVALID with the FIFO empty -> M_RREADY=0, ERR=1 held; assert RST mid-burst -> all outputs at reset values, ERR=0, next grant goes to S0.
